// File: rtl/tetris_keys_pkg.sv
// Shared PS/2 scan-code constants and parser state encoding for the tetris
// keyboard path (decoder, move and shape logic all import this).
package tetris_keys_pkg;

  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_BRK   = 8'hF0;
  localparam logic [7:0] KEY_DROP  = 8'h29;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_ROT   = 8'h75;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_EXT     = 2'd1,
    PS_BRK     = 2'd2,
    PS_EXT_BRK = 2'd3
  } ps2_state_e;

  // Drop is the only plain command; the arrows/rotate only count after E0.
  function automatic logic is_cmd(input ps2_state_e st, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    if (st == PS_IDLE) begin
      hit = (code == KEY_DROP);
    end else if (st == PS_EXT) begin
      hit = (code == KEY_LEFT) || (code == KEY_RIGHT) ||
            (code == KEY_DOWN) || (code == KEY_ROT);
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_cmd_decoder_if.sv
// Byte-strobe input and command output bundle between the PS/2 receiver,
// the command decoder and the game controller.
interface ps2_cmd_decoder_if;
  logic [7:0] ps2_byte;
  logic       ps2_valid;
  logic       press;
  logic [7:0] ps2_out;
  logic       busy;

  modport master (
    output ps2_byte, ps2_valid,
    input  press, ps2_out, busy
  );

  modport slave (
    input  ps2_byte, ps2_valid,
    output press, ps2_out, busy
  );
endinterface

// File: rtl/cmd_timer.sv
// Hold/gap timer: start raises press for PRESS_CYCLES cycles, then busy
// stays high for GAP_CYCLES more cycles before a new start is honoured.
module cmd_timer #(
  parameter int PRESS_CYCLES = 4000000,
  parameter int GAP_CYCLES   = 2000000
) (
  input  logic iVGA_CLK,
  input  logic reset,
  input  logic start,
  output logic press,
  output logic busy
);

  localparam int HW = (PRESS_CYCLES < 1) ? 1 : $clog2(PRESS_CYCLES + 1);
  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(PRESS_CYCLES);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);

  logic          press_q, press_d;
  logic          busy_q, busy_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  always_comb begin
    press_d    = press_q;
    busy_d     = busy_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    if (start && !busy_q) begin
      press_d    = 1'b1;
      busy_d     = 1'b1;
      hold_cnt_d = HW'(1);
    end else if (press_q) begin
      if (hold_cnt_q == HOLD_LAST) begin
        press_d    = 1'b0;
        hold_cnt_d = '0;
        if (GAP_CYCLES == 0) begin
          busy_d = 1'b0;
        end else begin
          gap_cnt_d = GW'(1);
        end
      end else begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end else if (busy_q) begin
      // busy is still high during the terminal gap cycle, so a code landing
      // exactly then is rejected by the decoder.
      if (gap_cnt_q == GAP_LAST) begin
        busy_d    = 1'b0;
        gap_cnt_d = '0;
      end else begin
        gap_cnt_d = gap_cnt_q + GW'(1);
      end
    end
  end

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      press_q    <= 1'b0;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      press_q    <= press_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign press = press_q;
  assign busy  = busy_q;

endmodule

// File: rtl/ps2_cmd_decoder.sv
// PS/2 scan-code parser: tracks E0/F0 prefixes, filters make codes down to
// the tetris command set and hands accepted codes to the hold/gap timer.
module ps2_cmd_decoder
  import tetris_keys_pkg::*;
#(
  parameter int PRESS_CYCLES = 4000000,
  parameter int GAP_CYCLES   = 2000000
) (
  input  logic               iVGA_CLK,
  input  logic               reset,
  ps2_cmd_decoder_if.slave   bus
);

  ps2_state_e state_q;
  logic [7:0] out_q;
  logic       accept;
  logic       press;
  logic       busy;

  assign accept = bus.ps2_valid && !busy && is_cmd(state_q, bus.ps2_byte);

  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      state_q <= PS_IDLE;
      out_q   <= 8'h00;
    end else if (bus.ps2_valid) begin
      unique case (state_q)
        PS_IDLE: begin
          if (bus.ps2_byte == KEY_EXT)      state_q <= PS_EXT;
          else if (bus.ps2_byte == KEY_BRK) state_q <= PS_BRK;
          else                              state_q <= PS_IDLE;
        end
        PS_EXT: begin
          if (bus.ps2_byte == KEY_BRK)      state_q <= PS_EXT_BRK;
          else if (bus.ps2_byte == KEY_EXT) state_q <= PS_EXT;
          else                              state_q <= PS_IDLE;
        end
        // Release byte (or a stray prefix) after F0 is swallowed.
        PS_BRK, PS_EXT_BRK: state_q <= PS_IDLE;
        default:            state_q <= PS_IDLE;
      endcase
      if (accept) begin
        out_q <= bus.ps2_byte;
      end
    end
  end

  cmd_timer #(
    .PRESS_CYCLES (PRESS_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_timer (
    .iVGA_CLK (iVGA_CLK),
    .reset    (reset),
    .start    (accept),
    .press    (press),
    .busy     (busy)
  );

  assign bus.press   = press;
  assign bus.busy    = busy;
  assign bus.ps2_out = out_q;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Directed bench for ps2_cmd_decoder with PRESS_CYCLES=8, GAP_CYCLES=4.
module tb_ps2_cmd_decoder;

  localparam int P = 8;
  localparam int G = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  ps2_cmd_decoder_if bus();

  ps2_cmd_decoder #(
    .PRESS_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .iVGA_CLK (clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         n;
    bit         exp_press;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Caller is always positioned at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    bus.ps2_byte  = b;
    bus.ps2_valid = 1'b1;
    @(negedge clk);
    bus.ps2_valid = 1'b0;
    bus.ps2_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("idle_timeout", 1, 0);
  endtask

  task automatic observe(output int pc, output int bc, output int first);
    pc    = 0;
    bc    = 0;
    first = int'(bus.press);
    for (int i = 0; i < 20; i++) begin
      pc += int'(bus.press);
      bc += int'(bus.busy);
      @(negedge clk);
    end
  endtask

  initial begin
    int pc, bc, fp;
    n_vec = 0;
    n_bad = 0;
    bus.ps2_byte  = 8'h00;
    bus.ps2_valid = 1'b0;

    vecs[0] = '{8'hE0, 8'h6B, 8'h00, 2, 1'b1, 8'h6B};
    vecs[1] = '{8'hE0, 8'hF0, 8'h6B, 3, 1'b0, 8'h6B};
    vecs[2] = '{8'h29, 8'h00, 8'h00, 1, 1'b1, 8'h29};
    vecs[3] = '{8'h1C, 8'h00, 8'h00, 1, 1'b0, 8'h29};
    vecs[4] = '{8'h6B, 8'h00, 8'h00, 1, 1'b0, 8'h29};
    vecs[5] = '{8'hE0, 8'hE0, 8'h72, 3, 1'b1, 8'h72};
    vecs[6] = '{8'hE0, 8'h74, 8'h00, 2, 1'b1, 8'h74};
    vecs[7] = '{8'hF0, 8'h29, 8'h00, 2, 1'b0, 8'h74};
    vecs[8] = '{8'hF0, 8'hE0, 8'h29, 3, 1'b1, 8'h29};
    vecs[9] = '{8'hE0, 8'h75, 8'h00, 2, 1'b1, 8'h75};

    rst = 1'b1;
    idle(3);
    check("reset_press", int'(bus.press), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_out", int'(bus.ps2_out), 8'h00);
    rst = 1'b0;
    idle(2);
    check("post_reset_press", int'(bus.press), 0);

    for (int v = 0; v < 10; v++) begin
      wait_idle();
      send_byte(vecs[v].b0);
      if (vecs[v].n > 1) send_byte(vecs[v].b1);
      if (vecs[v].n > 2) send_byte(vecs[v].b2);
      observe(pc, bc, fp);
      check($sformatf("v%0d_first_press", v), fp, vecs[v].exp_press ? 1 : 0);
      check($sformatf("v%0d_press_cycles", v), pc, vecs[v].exp_press ? P : 0);
      check($sformatf("v%0d_busy_cycles", v), bc, vecs[v].exp_press ? P + G : 0);
      check($sformatf("v%0d_out", v), int'(bus.ps2_out), int'(vecs[v].exp_out));
    end

    // Codes during hold, and a code landing on the gap-expiry edge, are dropped.
    wait_idle();
    send_byte(8'h29);
    send_byte(8'hE0);
    send_byte(8'h74);
    idle(8);
    check("hold_drop_out", int'(bus.ps2_out), 8'h29);
    check("gap_busy", int'(bus.busy), 1);
    send_byte(8'hE0);
    send_byte(8'h74);
    check("expiry_drop_press", int'(bus.press), 0);
    check("expiry_drop_busy", int'(bus.busy), 0);
    check("expiry_drop_out", int'(bus.ps2_out), 8'h29);
    send_byte(8'hE0);
    send_byte(8'h74);
    check("after_gap_press", int'(bus.press), 1);
    check("after_gap_out", int'(bus.ps2_out), 8'h74);

    // Reset in hold cycle 3 clears press/busy without waiting for a clock.
    idle(30);
    send_byte(8'h29);
    idle(2);
    check("hold3_press", int'(bus.press), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_press", int'(bus.press), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_out", int'(bus.ps2_out), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    observe(pc, bc, fp);
    check("rst_release_no_press", pc, 0);
    send_byte(8'hE0);
    send_byte(8'h75);
    observe(pc, bc, fp);
    check("rst_then_75_press", pc, P);
    check("rst_then_75_busy", bc, P + G);
    check("rst_then_75_out", int'(bus.ps2_out), 8'h75);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ps2_cmd_decoder.md
PS2_CMD_DECODER -- requirements
Module: ps2_cmd_decoder

Interface
REQ-001 SHALL have parameter PRESS_CYCLES, default 4000000, the number of iVGA_CLK cycles that `press` stays high per accepted command.
REQ-002 SHALL have parameter GAP_CYCLES, default 2000000, the minimum number of cycles from the fall of `press` to the next accepted command.
REQ-003 SHALL have port iVGA_CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ps2_byte, input, 8 bits: scan-code byte from the PS/2 receiver.
REQ-006 SHALL have port ps2_valid, input, 1 bit: one-cycle strobe; ps2_byte is valid in that cycle.
REQ-007 SHALL have port press, output, 1 bit: command-pending level, consumed by the VGA/game controller.
REQ-008 SHALL have port ps2_out, output, 8 bits: the command code, stable while press is high and held afterwards.
REQ-009 SHALL have port busy, output, 1 bit: high while press is high or the gap is still running.

Function
REQ-010 SHALL implement parser states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 then F0 seen).
REQ-011 SHALL sample ps2_byte only in cycles where ps2_valid=1; every other cycle leaves the parser unchanged.
REQ-012 IDLE SHALL go to EXT on byte E0 and to BRK on byte F0; any other byte is a make code and returns the parser to IDLE.
REQ-013 EXT SHALL go to EXT_BRK on F0 and stay in EXT on E0; any other byte is an extended make code and returns the parser to IDLE.
REQ-014 BRK and EXT_BRK SHALL discard the next byte (the break/release code) and return to IDLE; E0 or F0 received there is also discarded.
REQ-015 The accepted command set SHALL be: non-extended 29 (drop/space); extended 6B (left), 74 (right), 72 (down), 75 (rotate). ps2_out carries that byte value, without E0.
REQ-016 Make codes outside the set, and make codes received while busy=1, SHALL be dropped silently; the parser still advances.
REQ-017 An accepted make code in cycle N SHALL load ps2_out and set press=1 from cycle N+1; press stays high for exactly PRESS_CYCLES cycles.
REQ-018 After press falls, busy SHALL stay high for exactly GAP_CYCLES more cycles; a command is accepted only when busy=0 in the ps2_valid cycle.
REQ-019 The hold and gap counters SHALL be wide enough for the parameters, SHALL not wrap, and SHALL saturate/clear at terminal count.
REQ-020 If an acceptable code arrives in the same cycle that the gap expires, it SHALL be dropped: busy is evaluated before the gap counter clears.
REQ-021 Make codes repeated by typematic auto-repeat SHALL be treated like new presses and are therefore limited to one per PRESS_CYCLES+GAP_CYCLES.

Reset
REQ-022 Asserting reset SHALL immediately set: parser=IDLE, press=0, busy=0, ps2_out=00, counters=0.
REQ-023 Reset asserted mid-hold or mid-gap SHALL abort the command; after release the block accepts a new command on the first valid strobe.
REQ-024 Reset SHALL deassert without a spurious press pulse.

Structure
REQ-025 Scan-code constants (E0, F0, 29, 6B, 74, 72, 75) and the parser state encoding SHALL live in a shared package, tetris_keys_pkg, reused by move and shape.
REQ-026 The hold/gap timer SHALL be one sub-module, cmd_timer (start, hold_cnt, gap_cnt, press, busy); parsing SHALL stay in ps2_cmd_decoder.

Verification (run with PRESS_CYCLES=8, GAP_CYCLES=4)
REQ-027 E0,6B -> ps2_out=6B, press high for 8 cycles starting the cycle after the 6B strobe, busy high for 12 cycles.
REQ-028 E0,F0,6B, then 29 -> no press for the release sequence; the 29 gives ps2_out=29 with a press pulse.
REQ-029 29 accepted, then E0,74 during hold or gap -> dropped, ps2_out stays 29; E0,74 sent after busy=0 -> accepted.
REQ-030 Unlisted 1C, and non-extended 6B -> no press, parser returns to IDLE.
REQ-031 Reset at hold cycle 3 -> press=0 and busy=0 in the same cycle; E0,75 after release -> accepted, ps2_out=75.
REQ-032 E0,E0,72 -> stays in EXT, then accepts 72.
